ps2_key_scanner: RTL and testbench
==================================

// Module: ps2_key_scanner
// PURPOSE
//  Receives PS/2 keyboard frames, decodes make/break sequences and holds the current key state for display.
//  Sits directly upstream of the 7-segment digit decoders.
//  scan_code[3:0]/[7:4] and key_cnt[3:0]/[7:4] each feed one decoder's 4-bit digit input.
//  disp_en gates the scan-code digits so they are blank while no key is held.
// PARAMETERS
//  TIMEOUT_CYC  5000  clk cycles with no ps2_clk falling edge before a partial frame is discarded
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock, asynchronous to clk
//  ps2_data   in   1  raw PS/2 data, asynchronous to clk
//  scan_code  out  8  make code of the most recently pressed key
//  key_cnt    out  8  BCD press count, two digits {tens,units}, 00..99
//  disp_en    out  1  1 while a key is held (scan_code digits lit)
//  byte_vld   out  1  1-cycle pulse: a good frame was received
//  rx_byte    out  8  received byte; valid when byte_vld=1
//  frame_err  out  1  1-cycle pulse: frame rejected (start/stop/parity)
// BEHAVIOUR
//  Reset: scan_code=0x00, key_cnt=0x00, disp_en=0, byte_vld=0, rx_byte=0x00, frame_err=0, FSM=IDLE.
//  Reset also clears the bit counter, shift register and timeout counter; a frame in progress is lost.
//  Sync: ps2_clk and ps2_data pass through 3-flop synchronisers.
//  A falling edge is sync[2:1]==2'b10; ps2_data is sampled (synchronised) in the same cycle.
//  Frame: 11 bits, LSB first: start(0), d[7:0], odd parity, stop(1). Bit counter 0..10.
//  On the 11th edge the frame is checked and the counter returns to 0.
//  Good frame: start==0, stop==1, ^{d,parity}==1. Then byte_vld=1 and rx_byte=d for exactly one cycle.
//  byte_vld rises the cycle after the stop-bit edge is detected. Otherwise frame_err=1 for one cycle and the byte is dropped.
//  Timeout: a counter runs while bit counter!=0 and clears on every falling edge.
//  When it reaches TIMEOUT_CYC, the bit counter returns to 0 with no error pulse.
//  If an edge and expiry fall in the same cycle, the edge wins.
//  Key FSM advances only on byte_vld cycles. Outputs update on the clock edge that ends the byte_vld cycle.
//  0xE0 prefix bytes are ignored in every state.
//   IDLE  : F0 -> BREAK.
//           other byte -> scan_code=byte, disp_en=1, key_cnt+=1, -> HELD.
//   HELD  : byte==scan_code (typematic repeat) -> no change.
//           F0 -> BREAK.
//           other byte -> scan_code=byte, key_cnt+=1, stay HELD (new key while another is held).
//   BREAK : byte==scan_code -> disp_en=0, -> IDLE.
//           other byte (release of a non-current key) -> disp_en unchanged, -> HELD if disp_en else IDLE.
//  scan_code holds its last value after release; only disp_en drops.
//  key_cnt: BCD add-1; units 9 -> 0 carries into tens; 99 -> 00. It counts presses, never repeats.
//  A back-to-back frame may start while byte_vld is high; the receiver never stalls.
// TESTING
//  1 rst, then frame 0x1C (parity 0) -> byte_vld pulse, rx_byte=1C, scan_code=1C, disp_en=1, key_cnt=01.
//  2 0x1C repeated x3, then F0 1C -> key_cnt stays 01; after 1C, disp_en=0 and scan_code=1C.
//  3 0x1C sent with parity=1 -> frame_err pulse, no byte_vld, scan_code/key_cnt/FSM unchanged.
//  4 From reset, press/release 100 keys (code N, F0 N) -> key_cnt goes 09->10, reaches 99, then 00.
//  5 Send 5 bits, idle TIMEOUT_CYC+1 clks, then full frame 0x32 -> no frame_err, scan_code=32, key_cnt=01.
//  6 Press 1C, then 0x32, then F0 1C, then F0 32 -> disp_en=1 throughout the F0 1C step; scan_code=32, key_cnt=02; disp_en=0 only after F0 32.
//  7 Assert rst after bit 6 of a frame, release, then send 0x1C -> outputs at reset values, then 0x1C decoded with no error.

Source files
------------

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard receiver with make/break decoding.
// Frames are received from the synchronised PS/2 lines. Each good byte is
// passed through the key-state FSM, which tracks the held key, the display
// enable and a two-digit BCD press counter for the 7-segment decoders.
module ps2_key_scanner #(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic [7:0] key_cnt,
    output logic       disp_en,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_BREAK = 2'd2
    } key_state_t;

    // Odd parity over data and parity bit: the XOR of all nine bits is 1.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Two-digit BCD increment, wrapping 99 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    logic [2:0]      ps2_clk_sync_r;
    logic [2:0]      ps2_data_sync_r;
    logic            fall_s;
    logic            data_s;
    logic [3:0]      bit_cnt_r;
    logic [9:0]      shift_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            frame_ok_s;
    logic            byte_vld_r;
    logic [7:0]      rx_byte_r;
    logic            frame_err_r;

    key_state_t      state_r;
    key_state_t      state_nxt_s;
    logic [7:0]      scan_code_r;
    logic [7:0]      scan_code_nxt_s;
    logic [7:0]      key_cnt_r;
    logic [7:0]      key_cnt_nxt_s;
    logic            disp_en_r;
    logic            disp_en_nxt_s;

    // Three-flop synchronisers; reset to the idle-high line level so no
    // false falling edge appears when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_sync_r  <= 3'b111;
            ps2_data_sync_r <= 3'b111;
        end else begin
            ps2_clk_sync_r  <= {ps2_clk_sync_r[1:0], ps2_clk};
            ps2_data_sync_r <= {ps2_data_sync_r[1:0], ps2_data};
        end
    end

    assign fall_s = (ps2_clk_sync_r[2:1] == 2'b10);
    assign data_s = ps2_data_sync_r[2];

    // Frame is good when start is 0, the stop bit arriving now is 1 and
    // parity is odd. shift_r[0] holds the start bit, [8:1] data, [9] parity.
    assign frame_ok_s = (shift_r[0] == 1'b0) && (data_s == 1'b1) &&
                        odd_parity_ok(shift_r[9:1]);

    // Bit collection, frame check and partial-frame timeout. A falling edge
    // takes priority over an expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= 4'd0;
            shift_r     <= 10'd0;
            to_cnt_r    <= '0;
            byte_vld_r  <= 1'b0;
            rx_byte_r   <= 8'h00;
            frame_err_r <= 1'b0;
        end else begin
            byte_vld_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (fall_s) begin
                to_cnt_r <= '0;
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    if (frame_ok_s) begin
                        byte_vld_r <= 1'b1;
                        rx_byte_r  <= shift_r[8:1];
                    end else begin
                        frame_err_r <= 1'b1;
                    end
                end else begin
                    shift_r   <= {data_s, shift_r[9:1]};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (bit_cnt_r != 4'd0) begin
                if (to_cnt_r == TO_MAX) begin
                    bit_cnt_r <= 4'd0;
                    to_cnt_r  <= '0;
                end else begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    // Key-state registers; they change only at the end of a byte_vld cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            scan_code_r <= 8'h00;
            key_cnt_r   <= 8'h00;
            disp_en_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            scan_code_r <= scan_code_nxt_s;
            key_cnt_r   <= key_cnt_nxt_s;
            disp_en_r   <= disp_en_nxt_s;
        end
    end

    // Make/break decoding: next state and next display values.
    always_comb begin
        state_nxt_s     = state_r;
        scan_code_nxt_s = scan_code_r;
        key_cnt_nxt_s   = key_cnt_r;
        disp_en_nxt_s   = disp_en_r;
        if (byte_vld_r && (rx_byte_r != CODE_EXT)) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_byte_r == CODE_BREAK) begin
                        state_nxt_s = ST_BREAK;
                    end else begin
                        scan_code_nxt_s = rx_byte_r;
                        disp_en_nxt_s   = 1'b1;
                        key_cnt_nxt_s   = bcd_inc(key_cnt_r);
                        state_nxt_s     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (rx_byte_r == scan_code_r) begin
                        state_nxt_s = ST_HELD;
                    end else if (rx_byte_r == CODE_BREAK) begin
                        state_nxt_s = ST_BREAK;
                    end else begin
                        scan_code_nxt_s = rx_byte_r;
                        key_cnt_nxt_s   = bcd_inc(key_cnt_r);
                        state_nxt_s     = ST_HELD;
                    end
                end
                ST_BREAK: begin
                    if (rx_byte_r == scan_code_r) begin
                        disp_en_nxt_s = 1'b0;
                        state_nxt_s   = ST_IDLE;
                    end else if (disp_en_r) begin
                        state_nxt_s = ST_HELD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign scan_code = scan_code_r;
    assign key_cnt   = key_cnt_r;
    assign disp_en   = disp_en_r;
    assign byte_vld  = byte_vld_r;
    assign rx_byte   = rx_byte_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_key_scanner.sv
// Bench for ps2_key_scanner: PS/2 frames are bit-banged into the DUT, a
// reference key model predicts each byte's effect and pushes it to a
// scoreboard queue; a monitor pops and compares on every byte_vld pulse.
module tb_ps2_key_scanner;

    localparam int TIMEOUT_CYC = 5000;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic [7:0] key_cnt;
    logic       disp_en;
    logic       byte_vld;
    logic [7:0] rx_byte;
    logic       frame_err;

    ps2_key_scanner #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .key_cnt   (key_cnt),
        .disp_en   (disp_en),
        .byte_vld  (byte_vld),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [7:0] b;
        logic [7:0] scan;
        logic [7:0] cnt;
        logic       en;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   total = 0;
    int   bad   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    bit   pend = 1'b0;

    // reference key model
    int         m_state;   // 0 idle, 1 held, 2 break
    logic [7:0] m_scan;
    int         m_cnt;
    logic       m_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_scan  = 8'h00;
        m_cnt   = 0;
        m_en    = 1'b0;
    endtask

    // Apply one good byte to the model and queue the expected outcome.
    task automatic model_push(input logic [7:0] b);
        exp_t e;
        if (b != 8'hE0) begin
            case (m_state)
                0: if (b == 8'hF0) m_state = 2;
                   else begin m_scan = b; m_en = 1'b1; m_cnt = (m_cnt + 1) % 100; m_state = 1; end
                1: if (b == m_scan) m_state = 1;
                   else if (b == 8'hF0) m_state = 2;
                   else begin m_scan = b; m_cnt = (m_cnt + 1) % 100; end
                default: if (b == m_scan) begin m_en = 1'b0; m_state = 0; end
                         else m_state = m_en ? 1 : 0;
            endcase
        end
        e.b = b; e.scan = m_scan; e.cnt = to_bcd(m_cnt); e.en = m_en;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor, sampling on the falling system-clock edge.
    always @(negedge clk) begin
        if (pend) begin
            check_eq("scan_code", scan_code, cur_exp.scan);
            check_eq("key_cnt",   key_cnt,   cur_exp.cnt);
            check_eq("disp_en",   disp_en,   cur_exp.en);
            pend = 1'b0;
        end
        if (frame_err) err_seen++;
        if (byte_vld) begin
            check_eq("vld_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                cur_exp = exp_q.pop_front();
                check_eq("rx_byte", rx_byte, cur_exp.b);
                pend = 1'b1;
            end
        end
    end

    // Drive n frame bits LSB first; data changes while ps2_clk is high.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (4) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk); ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr, input logic serr);
        logic par;
        par = (~^b) ^ perr;
        if (!perr && !serr) model_push(b);
        else err_exp++;
        send_bits({~serr, par, b, 1'b0}, 11);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_scan"}, scan_code, 8'h00);
        check_eq({tag, "_cnt"},  key_cnt,   8'h00);
        check_eq({tag, "_en"},   disp_en,   1'b0);
        check_eq({tag, "_vld"},  byte_vld,  1'b0);
        check_eq({tag, "_rx"},   rx_byte,   8'h00);
        check_eq({tag, "_ferr"}, frame_err, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !pend) break;
            @(negedge clk);
        end
        check_eq({tag, "_drain"}, exp_q.size(), 0);
        check_eq({tag, "_errs"}, err_seen, err_exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        do_reset();
        check_reset_vals("rst");

        // 1: single press
        send_byte(8'h1C, 1'b0, 1'b0);
        drain("t1");
        // 2: typematic repeats then release
        repeat (3) send_byte(8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        drain("t2");
        // 3: bad parity, then bad stop bit; state must not move
        send_byte(8'h1C, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b1);
        drain("t3");
        check_eq("t3_scan", scan_code, 8'h1C);
        check_eq("t3_cnt",  key_cnt,   8'h01);
        check_eq("t3_en",   disp_en,   1'b0);
        // E0 prefix is ignored by the key FSM
        send_byte(8'hE0, 1'b0, 1'b0);
        drain("t3e");

        // 4: 100 press/release pairs, counter wraps 99 -> 00
        do_reset();
        for (int k = 0; k < 100; k++) begin
            send_byte(8'(k + 1), 1'b0, 1'b0);
            send_byte(8'hF0, 1'b0, 1'b0);
            send_byte(8'(k + 1), 1'b0, 1'b0);
            drain("t4");
        end
        check_eq("t4_wrap", key_cnt, 8'h00);

        // 5: partial frame abandoned by timeout
        do_reset();
        send_bits(11'b000_0101_1010, 5);
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        send_byte(8'h32, 1'b0, 1'b0);
        drain("t5");
        check_eq("t5_scan", scan_code, 8'h32);
        check_eq("t5_cnt",  key_cnt,   8'h01);

        // 6: overlapping keys
        do_reset();
        send_byte(8'h1C, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        drain("t6a");
        check_eq("t6_en_held", disp_en, 1'b1);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        drain("t6b");
        check_eq("t6_scan", scan_code, 8'h32);
        check_eq("t6_cnt",  key_cnt,   8'h02);

        // 7: reset in the middle of a frame
        send_byte(8'h1C, 1'b0, 1'b0);
        drain("t7pre");
        send_bits(11'b110_0001_1100 & 11'h07F, 7);
        do_reset();
        check_reset_vals("t7rst");
        send_byte(8'h1C, 1'b0, 1'b0);
        drain("t7");
        check_eq("t7_scan", scan_code, 8'h1C);
        check_eq("t7_cnt",  key_cnt,   8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
